// File: rtl/wave_capture_if.sv
// wave_capture_if
//   Groups the sample input stream, the display-idle hint and the RAM
//   write port of the waveform capture sequencer.
//   master : the sample source / display side (drives samples and idle,
//            observes the RAM write port and read_index)
//   slave  : the capture controller (wave_capture_ctrl)
// Signals
//   new_sample_ready   one-cycle strobe, new_sample_in valid
//   new_sample_in      signed audio sample
//   wave_display_idle  display not scanning the wave area
//   write_address      RAM write address {back half, index}
//   write_enable       RAM write strobe
//   write_sample       RAM write data (offset-binary)
//   read_index         half currently scanned by the display
//   capturing          capture in progress
interface wave_capture_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int VALUE_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 9
);
    logic                    new_sample_ready;
    logic [SAMPLE_WIDTH-1:0] new_sample_in;
    logic                    wave_display_idle;
    logic [ADDR_WIDTH-1:0]   write_address;
    logic                    write_enable;
    logic [VALUE_WIDTH-1:0]  write_sample;
    logic                    read_index;
    logic                    capturing;

    modport master (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index, capturing
    );

    modport slave (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_address, write_enable, write_sample, read_index, capturing
    );
endinterface

// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl
//   Fills the back half of a double-buffered 512x8 waveform RAM. A capture
//   of 256 consecutive samples starts on a positive zero crossing; once the
//   half is full the halves are swapped only while the display is idle, so
//   the scan never shows a partial frame.
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    wave_capture_if.slave (sample input, idle hint, RAM write port)
// Configuration
//   WAVE_CAPTURE_TIMEOUT_EN  when defined, ARMED forces a trigger on the
//                            sample after TIMEOUT_SAMPLES non-triggering
//                            samples, so silence/DC still refreshes.
//
// state  | meaning
// ARMED  | waiting for a zero crossing (or timeout)
// ACTIVE | writing samples into the back half
// WAIT   | back half full, waiting for display idle to swap halves
module wave_capture_ctrl #(
    parameter int SAMPLE_WIDTH    = 16,
    parameter int VALUE_WIDTH     = 8,
    parameter int ADDR_WIDTH      = 9,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    wave_capture_if.slave   bus
);
    localparam int IDX_W = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

    state_t           state;
    logic [IDX_W-1:0] count;
    // Only the sign of the previous sample matters for crossing detection.
    logic             prev_sign;
    logic             trigger;
    logic             timeout_hit;
    logic             start;
    logic [VALUE_WIDTH-1:0] sample_value;

    assign trigger = bus.new_sample_ready && prev_sign && !bus.new_sample_in[SAMPLE_WIDTH-1];
    assign start   = (state == ARMED) && (trigger || (bus.new_sample_ready && timeout_hit));

    // Top bits with MSB inverted: two's complement -> offset binary.
    assign sample_value = bus.new_sample_in[SAMPLE_WIDTH-1 -: VALUE_WIDTH]
                          ^ {1'b1, {(VALUE_WIDTH-1){1'b0}}};

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TO_W-1:0] timeout_cnt;

    assign timeout_hit = (timeout_cnt == TO_W'(TIMEOUT_SAMPLES));

    // Saturates at TIMEOUT_SAMPLES; the following sample then triggers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt <= '0;
        end else if (state != ARMED || start) begin
            timeout_cnt <= '0;
        end else if (bus.new_sample_ready && !timeout_hit) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ARMED;
            count             <= '0;
            prev_sign         <= 1'b0;
            bus.read_index    <= 1'b0;
            bus.write_enable  <= 1'b0;
            bus.write_address <= '0;
            bus.write_sample  <= '0;
            bus.capturing     <= 1'b0;
        end else begin
            bus.write_enable <= 1'b0;
            if (bus.new_sample_ready) begin
                prev_sign <= bus.new_sample_in[SAMPLE_WIDTH-1];
            end

            case (state)
                ARMED: begin
                    if (start) begin
                        bus.write_enable  <= 1'b1;
                        bus.write_address <= {~bus.read_index, {IDX_W{1'b0}}};
                        bus.write_sample  <= sample_value;
                        count             <= IDX_W'(1);
                        state             <= ACTIVE;
                        bus.capturing     <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (bus.new_sample_ready) begin
                        bus.write_enable  <= 1'b1;
                        bus.write_address <= {~bus.read_index, count};
                        bus.write_sample  <= sample_value;
                        count             <= count + 1'b1;
                        if (count == {IDX_W{1'b1}}) begin
                            state         <= WAIT;
                            bus.capturing <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (bus.wave_display_idle) begin
                        bus.read_index <= ~bus.read_index;
                        state          <= ARMED;
                    end
                end
                default: begin
                    state         <= ARMED;
                    bus.capturing <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wave_capture_ctrl.sv
// tb_wave_capture_ctrl
//   Drives directed and random sample streams into wave_capture_ctrl and
//   compares every cycle against a behavioural capture model, plus literal
//   expectations for the key scenarios.
module tb_wave_capture_ctrl;
    localparam int TIMEOUT = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wave_capture_if #(.SAMPLE_WIDTH(16), .VALUE_WIDTH(8), .ADDR_WIDTH(9)) bus ();

    wave_capture_ctrl #(
        .SAMPLE_WIDTH(16), .VALUE_WIDTH(8), .ADDR_WIDTH(9), .TIMEOUT_SAMPLES(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;

    // Behavioural model: phase 0 = armed, 1 = filling, 2 = full/waiting.
    int         m_phase;
    int         m_n;
    int         m_prev;
    int         m_to;
    logic       m_ri;
    logic       exp_we;
    logic [8:0] exp_addr;
    logic [7:0] exp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_phase  = 0;
        m_n      = 0;
        m_prev   = 0;
        m_to     = 0;
        m_ri     = 1'b0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic emit(input int idx, input int sv);
        exp_we   = 1'b1;
        exp_addr = 9'((m_ri ? 0 : 256) + idx);
        exp_data = 8'((sv >>> 8) + 128);
    endtask

    task automatic model_edge(input logic rdy, input logic [15:0] s, input logic idl);
        int  sv;
        bit  crossing;
        bit  forced;
        sv       = int'($signed(s));
        crossing = rdy && (m_prev < 0) && (sv >= 0);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        forced   = rdy && (m_to >= TIMEOUT);
`else
        forced   = 1'b0;
`endif
        exp_we = 1'b0;
        if (m_phase == 0) begin
            if (crossing || forced) begin
                emit(0, sv);
                m_n     = 1;
                m_phase = 1;
                m_to    = 0;
            end else if (rdy && m_to < TIMEOUT) begin
                m_to++;
            end
        end else if (m_phase == 1) begin
            if (rdy) begin
                emit(m_n, sv);
                m_n++;
                if (m_n == 256) m_phase = 2;
            end
        end else if (idl) begin
            m_ri    = ~m_ri;
            m_phase = 0;
            m_to    = 0;
        end
        if (rdy) m_prev = sv;
    endtask

    task automatic compare_all();
        chk("write_enable", 32'(bus.write_enable), 32'(exp_we));
        chk("write_address", 32'(bus.write_address), 32'(exp_addr));
        chk("write_sample", 32'(bus.write_sample), 32'(exp_data));
        chk("read_index", 32'(bus.read_index), 32'(m_ri));
        chk("capturing", 32'(bus.capturing), 32'(m_phase == 1));
    endtask

    task automatic step(input logic rdy, input logic [15:0] s, input logic idl);
        bus.new_sample_ready  = rdy;
        bus.new_sample_in     = s;
        bus.wave_display_idle = idl;
        @(posedge clk);
        model_edge(rdy, s, idl);
        @(negedge clk);
        compare_all();
        if (bus.write_enable) wr_pulses++;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_we"}, 32'(bus.write_enable), 32'd0);
        chk({tag, "_addr"}, 32'(bus.write_address), 32'd0);
        chk({tag, "_data"}, 32'(bus.write_sample), 32'd0);
        chk({tag, "_ri"}, 32'(bus.read_index), 32'd0);
        chk({tag, "_cap"}, 32'(bus.capturing), 32'd0);
    endtask

    // Assert reset between edges and check that outputs clear at once.
    task automatic pulse_reset(input string tag);
        bus.new_sample_ready  = 1'b0;
        bus.wave_display_idle = 1'b0;
        #2 reset = 1'b1;
        model_clear();
        #1 check_cleared(tag);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // Fill the rest of a capture (indices 1..255) with random gaps.
    task automatic fill_rest(input bit gaps);
        for (int k = 1; k < 256; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 16'(($urandom)), 1'($urandom));
            step(1'b1, 16'($urandom), 1'b0);
        end
    endtask

    int snap;

    initial begin
        reset = 1'b1;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;
        model_clear();
        @(negedge clk);
        #1 check_cleared("reset");
        #1 reset = 1'b0;

        // 1: -5 then +3 triggers; first write at 0x100 with 0x80.
        step(1'b1, -16'sd5, 1'b0);
        chk("t1_armed_cap", 32'(bus.capturing), 32'd0);
        step(1'b1, 16'sd3, 1'b0);
        chk("t1_addr", 32'(bus.write_address), 32'h100);
        chk("t1_data", 32'(bus.write_sample), 32'h80);
        chk("t1_we", 32'(bus.write_enable), 32'd1);
        chk("t1_cap", 32'(bus.capturing), 32'd1);
        chk("t1_model_addr", 32'(exp_addr), 32'h100);

        // 2: fill with full-scale extremes, then one ignored strobe.
        for (int k = 1; k < 256; k++) begin
            logic [15:0] s;
            repeat ($urandom_range(0, 2)) step(1'b0, 16'h0, 1'($urandom));
            s = (k == 10) ? 16'h7FFF : (k == 11) ? 16'h8000 : 16'($urandom);
            step(1'b1, s, 1'b0);
            if (k == 10) chk("t2_data_max", 32'(bus.write_sample), 32'hFF);
            if (k == 11) chk("t2_data_min", 32'(bus.write_sample), 32'h00);
        end
        chk("t2_last_addr", 32'(bus.write_address), 32'h1FF);
        chk("t2_cap_off", 32'(bus.capturing), 32'd0);
        step(1'b1, 16'h1234, 1'b0);
        chk("t2_no_write", 32'(bus.write_enable), 32'd0);

        // 3: no swap without idle; swap one cycle after idle; next capture in half 0.
        repeat (50) step(1'b0, 16'h0, 1'b0);
        chk("t3_ri_hold", 32'(bus.read_index), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("t3_ri_swap", 32'(bus.read_index), 32'd1);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'h0001, 1'b0);
        chk("t3_first_addr", 32'(bus.write_address), 32'h000);
        fill_rest(1'b1);
        chk("t3_last_addr", 32'(bus.write_address), 32'h0FF);
        step(1'b0, 16'h0, 1'b1);
        chk("t3_ri_back", 32'(bus.read_index), 32'd0);

        // 4: positive DC only.
        pulse_reset("t4_reset");
        snap = wr_pulses;
        repeat (2000) step(1'b1, 16'd100, 1'b0);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        chk("t4_dc_writes", 32'(wr_pulses - snap), 32'd256);
`else
        chk("t4_dc_writes", 32'(wr_pulses - snap), 32'd0);
`endif

        // 5: reset in the middle of a capture.
        pulse_reset("t5_pre");
        step(1'b1, -16'sd5, 1'b0);
        step(1'b1, 16'sd3, 1'b0);
        repeat (99) step(1'b1, 16'($urandom), 1'b0);
        chk("t5_addr_at_99", 32'(bus.write_address), 32'h163);
        pulse_reset("t5_mid");
        snap = wr_pulses;
        repeat (20) step(1'b1, 16'd7, 1'b0);
        chk("t5_no_writes", 32'(wr_pulses - snap), 32'd0);

        // 6: back-to-back strobes through a full capture.
        step(1'b1, -16'sd2, 1'b0);
        snap = wr_pulses;
        step(1'b1, 16'sd2, 1'b0);
        fill_rest(1'b0);
        step(1'b0, 16'h0, 1'b0);
        chk("t6_pulses", 32'(wr_pulses - snap), 32'd256);

        // Random traffic, model-checked every cycle.
        repeat (3000) step(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 3) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
